arm_servo_ramp: RTL and testbench

Motion controller for the arm's servo PWM channels. Accepts per-joint target pulse widths over a valid/ready command port and slews each channel's duty toward its target by at most STEP per 20 ms frame. Its duty outputs drive the per-joint PWM generators (50 MHz clock units; 50_000 = 1 ms high time), so commanded jumps become smooth, rate-limited arm motion.

---
 rtl/arm_servo_ramp.sv | 262 ++++++++++++++++++++++++++
 tb/tb_arm_servo_ramp.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_servo_ramp.sv
// ============================================================================
// arm_servo_ramp
// ----------------------------------------------------------------------------
// Rate-limited motion controller for the arm's servo PWM channels.
//
// Per-joint target pulse widths arrive over a valid/ready command port. Once
// per frame the controller sweeps the channels in order, one per clock. Each
// channel's current duty moves toward its target by at most STEP. The
// current duties drive the per-joint PWM generators directly, so a commanded
// jump becomes a smooth, bounded-rate motion of the joint.
//
// Parameters
//   CH         number of servo channels (>= 2)
//   FRAME      frame length in clk cycles (2..2^20, and FRAME > CH+1)
//   STEP       largest duty change per channel per frame
//   DUTY_MIN   lower clamp applied to commanded duties
//   DUTY_MAX   upper clamp applied to commanded duties
//   DUTY_INIT  duty and target of every channel after reset
//
// Ports
//   clk         system clock (duty values are in units of this clock)
//   rst_n       synchronous, active-low reset
//   cmd_valid   a command is presented
//   cmd_ready   command accepted on a rising edge where valid && ready
//   cmd_ch      channel the command addresses (out-of-range is discarded)
//   cmd_duty    requested high time in clk cycles (clamped on accept)
//   duty_out    current duty, channel i at bits [i*20+19 : i*20]
//   frame_tick  one-cycle pulse in the last cycle of every frame
//   busy        registered: some channel has not yet reached its target
//   done        one-cycle pulse in the first cycle busy reads low again
// ============================================================================
module arm_servo_ramp #(
    parameter int CH        = 4,
    parameter int FRAME     = 1_000_000,
    parameter int STEP      = 500,
    parameter int DUTY_MIN  = 25_000,
    parameter int DUTY_MAX  = 125_000,
    parameter int DUTY_INIT = 75_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [$clog2(CH)-1:0] cmd_ch,
    input  logic [19:0]           cmd_duty,
    output logic [CH*20-1:0]      duty_out,
    output logic                  frame_tick,
    output logic                  busy,
    output logic                  done
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int IDX_W  = $clog2(CH);
    localparam int FCNT_W = $clog2(FRAME);

    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CH - 1);

    localparam logic [19:0] STEP_V      = 20'(STEP);
    localparam logic [19:0] DUTY_MIN_V  = 20'(DUTY_MIN);
    localparam logic [19:0] DUTY_MAX_V  = 20'(DUTY_MAX);
    localparam logic [19:0] DUTY_INIT_V = 20'(DUTY_INIT);

    typedef enum logic {
        S_IDLE,     // waiting for the frame tick, commands accepted
        S_UPDATE    // sweeping channels, one per cycle, commands stalled
    } state_t;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [FCNT_W-1:0] fcnt;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;

    logic [19:0]       cur [CH];   // duty currently driven to the PWM
    logic [19:0]       tgt [CH];   // clamped commanded duty

    logic              cmd_accept;
    logic [19:0]       cmd_duty_clamped;

    logic [19:0]       sel_cur;
    logic [19:0]       sel_tgt;
    logic [19:0]       sel_diff;
    logic              sel_up;
    logic [19:0]       sel_next;

    logic              any_diff;
    logic              busy_q;
    logic              done_q;

    // ------------------------------------------------------------------------
    // Frame counter: 0..FRAME-1, the tick marks its last count.
    // ------------------------------------------------------------------------
    assign frame_tick = (fcnt == FCNT_LAST);

    // NOTE: every clocked process uses non-blocking assignments so that all
    // registers sample their inputs at the same instant of the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt <= '0;
        end else if (frame_tick) begin
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + FCNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Sweep state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cmd_ready = 1'b0;

        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (frame_tick) begin
                    state_nxt = S_UPDATE;
                    idx_nxt   = '0;
                end
            end

            S_UPDATE: begin
                if (idx == IDX_LAST) begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Command path
    // ------------------------------------------------------------------------
    // A command accepted together with the frame tick is written at the same
    // edge the sweep starts, so the sweep already sees the new target.
    assign cmd_accept = cmd_valid && cmd_ready;

    always_comb begin
        if (cmd_duty < DUTY_MIN_V) begin
            cmd_duty_clamped = DUTY_MIN_V;
        end else if (cmd_duty > DUTY_MAX_V) begin
            cmd_duty_clamped = DUTY_MAX_V;
        end else begin
            cmd_duty_clamped = cmd_duty;
        end
    end

    // ------------------------------------------------------------------------
    // Slew computation for the channel selected by idx
    // ------------------------------------------------------------------------
    // The select is a compare-per-channel mux, so an idx value beyond CH-1
    // (possible when CH is not a power of two) never indexes past the array.
    always_comb begin
        sel_cur = '0;
        sel_tgt = '0;
        for (int i = 0; i < CH; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_cur = cur[i];
                sel_tgt = tgt[i];
            end
        end
    end

    // Both values stay inside [DUTY_MIN, DUTY_MAX], so the magnitude and the
    // +/- STEP moves cannot wrap.
    assign sel_up   = (sel_tgt > sel_cur);
    assign sel_diff = sel_up ? (sel_tgt - sel_cur) : (sel_cur - sel_tgt);

    always_comb begin
        if (sel_diff > STEP_V) begin
            sel_next = sel_up ? (sel_cur + STEP_V) : (sel_cur - STEP_V);
        end else begin
            sel_next = sel_tgt;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel duty and target storage
    // ------------------------------------------------------------------------
    // NOTE: these arrays are reset on purpose: every channel must restart at
    // DUTY_INIT, so they are built from flops rather than a RAM.
    // A command for a channel number >= CH matches no entry and is dropped
    // while its handshake still completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                cur[i] <= DUTY_INIT_V;
                tgt[i] <= DUTY_INIT_V;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (cmd_accept && (cmd_ch == IDX_W'(i))) begin
                    tgt[i] <= cmd_duty_clamped;
                end
                if ((state == S_UPDATE) && (idx == IDX_W'(i))) begin
                    cur[i] <= sel_next;
                end
            end
        end
    end

    always_comb begin
        duty_out = '0;
        for (int i = 0; i < CH; i++) begin
            duty_out[i*20 +: 20] = cur[i];
        end
    end

    // ------------------------------------------------------------------------
    // Busy / done
    // ------------------------------------------------------------------------
    always_comb begin
        any_diff = 1'b0;
        for (int i = 0; i < CH; i++) begin
            any_diff = any_diff | (cur[i] != tgt[i]);
        end
    end

    // done is computed from the value busy_q is about to take, so it rises
    // in the same cycle that busy first reads low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= any_diff;
            done_q <= busy_q && !any_diff;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_arm_servo_ramp.sv
// ============================================================================
// tb_arm_servo_ramp
// ----------------------------------------------------------------------------
// Directed bench for arm_servo_ramp. A 4-channel instance carries most of the
// scenarios; a 3-channel instance exercises the out-of-range channel number.
// Both use FRAME = 20 and STEP = 5000 so ramps finish within a few frames.
// Outputs are sampled 1 time unit after the rising edge.
// ============================================================================
module tb_arm_servo_ramp;

    localparam int FRAME = 20;
    localparam int STEP  = 5000;

    logic        clk = 1'b0;
    logic        rst_n;

    // 4-channel instance
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ch;
    logic [19:0] cmd_duty;
    logic [79:0] duty_out;
    logic        frame_tick;
    logic        busy;
    logic        done;

    // 3-channel instance
    logic        cmd_valid3;
    logic        cmd_ready3;
    logic [1:0]  cmd_ch3;
    logic [19:0] cmd_duty3;
    logic [59:0] duty_out3;
    logic        frame_tick3;
    logic        busy3;
    logic        done3;

    int total     = 0;
    int bad       = 0;
    int done_cnt  = 0;
    int done3_cnt = 0;

    always #5 clk = ~clk;

    arm_servo_ramp #(
        .CH(4), .FRAME(FRAME), .STEP(STEP),
        .DUTY_MIN(25_000), .DUTY_MAX(125_000), .DUTY_INIT(75_000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_duty   (cmd_duty),
        .duty_out   (duty_out),
        .frame_tick (frame_tick),
        .busy       (busy),
        .done       (done)
    );

    arm_servo_ramp #(
        .CH(3), .FRAME(FRAME), .STEP(STEP),
        .DUTY_MIN(25_000), .DUTY_MAX(125_000), .DUTY_INIT(75_000)
    ) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid3),
        .cmd_ready  (cmd_ready3),
        .cmd_ch     (cmd_ch3),
        .cmd_duty   (cmd_duty3),
        .duty_out   (duty_out3),
        .frame_tick (frame_tick3),
        .busy       (busy3),
        .done       (done3)
    );

    // Count done pulses mid-cycle.
    always @(negedge clk) begin
        if (done === 1'b1)  done_cnt++;
        if (done3 === 1'b1) done3_cnt++;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1);
    end

    function automatic logic [19:0] duty_of(input int i);
        return duty_out[i*20 +: 20];
    endfunction

    function automatic logic [19:0] duty3_of(input int i);
        return duty_out3[i*20 +: 20];
    endfunction

    task automatic step_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench in the first cycle after the last reset edge (fcnt=0).
    task automatic do_reset();
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_valid3 = 1'b0;
        step_cycles(2);
        rst_n = 1'b1;
    endtask

    // Advance until a cycle with frame_tick high; n = cycles advanced.
    task automatic wait_tick(output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < 3*FRAME) begin
            step_cycles(1);
            n++;
            if (frame_tick === 1'b1) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL wait_tick: no frame_tick within %0d cycles", 3*FRAME);
        end
    endtask

    // Present a command to the 4-channel instance until it is accepted.
    task automatic send_cmd(input logic [1:0] ch, input logic [19:0] duty);
        int waits;
        cmd_valid = 1'b1;
        cmd_ch    = ch;
        cmd_duty  = duty;
        waits     = 0;
        while (cmd_ready !== 1'b1 && waits < 50) begin
            step_cycles(1);
            waits++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_cmd ch%0d: cmd_ready=%b required 1 within 50 cycles", ch, cmd_ready);
        end
        step_cycles(1);
        cmd_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        int n;
        int d0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_ch     = '0;
        cmd_duty   = '0;
        cmd_valid3 = 1'b0;
        cmd_ch3    = '0;
        cmd_duty3  = '0;
        step_cycles(3);

        total++; if (cmd_ready !== 1'b1)  begin bad++; $display("FAIL reset cmd_ready: got %b expected 1", cmd_ready); end
        total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset frame_tick: got %b expected 0", frame_tick); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset done: got %b expected 0", done); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (duty_of(i) !== 20'd75_000) begin
                bad++; $display("FAIL reset duty ch%0d: got %0d expected 75000", i, duty_of(i));
            end
        end

        rst_n = 1'b1;
        d0 = done_cnt;

        // fcnt is 0 in this cycle, so the tick is FRAME-1 cycles later.
        wait_tick(n);
        total++; if (n != FRAME-1) begin bad++; $display("FAIL first tick: got %0d cycles expected %0d", n, FRAME-1); end
        step_cycles(1);
        total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL tick width: got %b expected 0", frame_tick); end
        wait_tick(n);
        total++; if (n != FRAME-1) begin bad++; $display("FAIL tick period a: got %0d expected %0d", n + 1, FRAME); end
        wait_tick(n);
        total++; if (n != FRAME) begin bad++; $display("FAIL tick period b: got %0d expected %0d", n, FRAME); end

        for (int i = 0; i < 4; i++) begin
            total++;
            if (duty_of(i) !== 20'd75_000) begin
                bad++; $display("FAIL idle duty ch%0d: got %0d expected 75000", i, duty_of(i));
            end
        end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL idle busy: got %b expected 0", busy); end
        total++; if (done_cnt != d0)   begin bad++; $display("FAIL idle done pulses: got %0d expected 0", done_cnt - d0); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_ramp_up();
        int n;
        int d0;
        logic [19:0] prev;
        logic [19:0] expv;
        step_cycles(6);
        send_cmd(2'd1, 20'd100_000);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ramp busy lag: got %b expected 0", busy); end
        step_cycles(1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ramp busy rise: got %b expected 1", busy); end
        d0 = done_cnt;
        prev = 20'd75_000;
        for (int k = 1; k <= 5; k++) begin
            wait_tick(n);
            step_cycles(2);
            total++;
            if (duty_of(1) !== prev) begin bad++; $display("FAIL ramp early f%0d: got %0d expected %0d", k, duty_of(1), prev); end
            total++;
            if (busy !== 1'b1) begin bad++; $display("FAIL ramp busy f%0d: got %b expected 1", k, busy); end
            step_cycles(1);
            expv = 20'(75_000 + 5_000*k);
            total++;
            if (duty_of(1) !== expv) begin bad++; $display("FAIL ramp step f%0d: got %0d expected %0d", k, duty_of(1), expv); end
            prev = expv;
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ramp busy last: got %b expected 1", busy); end
        step_cycles(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ramp busy fall: got %b expected 0", busy); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ramp done: got %b expected 1", done); end
        step_cycles(1);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL ramp done width: got %b expected 0", done); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL ramp done count: got %0d expected 1", done_cnt - d0); end
        for (int i = 0; i < 4; i++) begin
            if (i != 1) begin
                total++;
                if (duty_of(i) !== 20'd75_000) begin
                    bad++; $display("FAIL ramp other ch%0d: got %0d expected 75000", i, duty_of(i));
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_tick_cmd();
        int n;
        logic [19:0] expv;
        wait_tick(n);
        step_cycles(FRAME);
        total++; if (frame_tick !== 1'b1) begin bad++; $display("FAIL tickcmd align: frame_tick got %b expected 1", frame_tick); end
        total++; if (cmd_ready !== 1'b1)  begin bad++; $display("FAIL tickcmd ready on tick: got %b expected 1", cmd_ready); end
        cmd_valid = 1'b1;
        cmd_ch    = 2'd0;
        cmd_duty  = 20'd80_000;
        step_cycles(1);
        // Second command lands in the sweep and must stall until it ends.
        cmd_ch   = 2'd2;
        cmd_duty = 20'd90_000;
        total++; if (duty_of(0) !== 20'd75_000) begin bad++; $display("FAIL tickcmd ch0 early: got %0d expected 75000", duty_of(0)); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cmd_ready !== 1'b0) begin bad++; $display("FAIL tickcmd stall T+%0d: cmd_ready got %b expected 0", i + 1, cmd_ready); end
            if (i == 1) begin
                total++;
                if (duty_of(0) !== 20'd80_000) begin bad++; $display("FAIL tickcmd ch0: got %0d expected 80000", duty_of(0)); end
            end
            step_cycles(1);
        end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL tickcmd ready T+5: got %b expected 1", cmd_ready); end
        step_cycles(1);
        cmd_valid = 1'b0;
        total++; if (duty_of(2) !== 20'd75_000) begin bad++; $display("FAIL tickcmd ch2 early: got %0d expected 75000", duty_of(2)); end
        step_cycles(1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL tickcmd ch2 busy: got %b expected 1", busy); end
        for (int k = 1; k <= 3; k++) begin
            wait_tick(n);
            step_cycles(5);
            expv = 20'(75_000 + 5_000*k);
            total++;
            if (duty_of(2) !== expv) begin bad++; $display("FAIL tickcmd ch2 f%0d: got %0d expected %0d", k, duty_of(2), expv); end
        end
        step_cycles(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL tickcmd settle busy: got %b expected 0", busy); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_clamp();
        int n;
        int d0;
        logic [19:0] exp1 [4];
        logic [19:0] expf [4];
        exp1[0] = 20'd70_000;  exp1[1] = 20'd75_000;  exp1[2] = 20'd77_000;  exp1[3] = 20'd80_000;
        expf[0] = 20'd25_000;  expf[1] = 20'd75_000;  expf[2] = 20'd77_000;  expf[3] = 20'd125_000;
        do_reset();
        send_cmd(2'd0, 20'd10_000);
        send_cmd(2'd2, 20'd77_000);
        send_cmd(2'd3, 20'd200_000);
        d0 = done_cnt;
        wait_tick(n);
        step_cycles(5);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (duty_of(i) !== exp1[i]) begin bad++; $display("FAIL clamp f1 ch%0d: got %0d expected %0d", i, duty_of(i), exp1[i]); end
        end
        for (int f = 2; f <= 10; f++) begin
            wait_tick(n);
            step_cycles(5);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (duty_of(i) !== expf[i]) begin bad++; $display("FAIL clamp f10 ch%0d: got %0d expected %0d", i, duty_of(i), expf[i]); end
        end
        wait_tick(n);
        step_cycles(5);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (duty_of(i) !== expf[i]) begin bad++; $display("FAIL clamp hold ch%0d: got %0d expected %0d", i, duty_of(i), expf[i]); end
        end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL clamp busy: got %b expected 0", busy); end
        total++; if (done_cnt - d0 != 1)   begin bad++; $display("FAIL clamp done count: got %0d expected 1", done_cnt - d0); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_invalid_channel();
        int waits;
        int d3;
        int busy_err;
        cmd_valid3 = 1'b1;
        cmd_ch3    = 2'd3;
        cmd_duty3  = 20'd100_000;
        waits = 0;
        while (cmd_ready3 !== 1'b1 && waits < 50) begin
            step_cycles(1);
            waits++;
        end
        total++; if (cmd_ready3 !== 1'b1) begin bad++; $display("FAIL invalid handshake: cmd_ready got %b expected 1", cmd_ready3); end
        step_cycles(1);
        cmd_valid3 = 1'b0;
        d3 = done3_cnt;
        busy_err = 0;
        for (int i = 0; i < 2*FRAME; i++) begin
            step_cycles(1);
            if (busy3 !== 1'b0) busy_err++;
        end
        total++; if (busy_err != 0) begin bad++; $display("FAIL invalid busy: high in %0d cycles expected 0", busy_err); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (duty3_of(i) !== 20'd75_000) begin bad++; $display("FAIL invalid duty ch%0d: got %0d expected 75000", i, duty3_of(i)); end
        end
        total++; if (done3_cnt != d3) begin bad++; $display("FAIL invalid done: got %0d pulses expected 0", done3_cnt - d3); end

        // A valid command on the same instance must still take effect.
        cmd_valid3 = 1'b1;
        cmd_ch3    = 2'd2;
        cmd_duty3  = 20'd100_000;
        waits = 0;
        while (cmd_ready3 !== 1'b1 && waits < 50) begin
            step_cycles(1);
            waits++;
        end
        step_cycles(1);
        cmd_valid3 = 1'b0;
        step_cycles(1);
        total++; if (busy3 !== 1'b1) begin bad++; $display("FAIL invalid followup busy: got %b expected 1", busy3); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_ramp();
        int n;
        int d0;
        do_reset();
        send_cmd(2'd1, 20'd100_000);
        wait_tick(n);
        step_cycles(2);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst ramp active: busy got %b expected 1", busy); end
        rst_n = 1'b0;
        d0 = done_cnt;
        step_cycles(1);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (duty_of(i) !== 20'd75_000) begin bad++; $display("FAIL midrst duty ch%0d: got %0d expected 75000", i, duty_of(i)); end
        end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL midrst busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL midrst done: got %b expected 0", done); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst cmd_ready: got %b expected 1", cmd_ready); end
        // Command presented while reset is held must be ignored.
        cmd_valid = 1'b1;
        cmd_ch    = 2'd2;
        cmd_duty  = 20'd100_000;
        step_cycles(1);
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        wait_tick(n);
        total++; if (n != FRAME-1) begin bad++; $display("FAIL midrst fcnt restart: tick after %0d cycles expected %0d", n, FRAME-1); end
        step_cycles(5);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (duty_of(i) !== 20'd75_000) begin bad++; $display("FAIL midrst post duty ch%0d: got %0d expected 75000", i, duty_of(i)); end
        end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL midrst post busy: got %b expected 0", busy); end
        total++; if (done_cnt != d0)   begin bad++; $display("FAIL midrst done pulses: got %0d expected 0", done_cnt - d0); end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        test_reset();
        test_ramp_up();
        test_tick_cmd();
        test_clamp();
        test_invalid_channel();
        test_reset_mid_ramp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
